// File: rtl/lpc_record_serializer.sv
// -----------------------------------------------------------------------------
// lpc_record_serializer
//
// Purpose:
//   Sits behind the LPC decoder. Each rising edge of the decoder's strobe
//   captures one record {cyctype_dir, data_size, addr, data} into a small
//   record FIFO. Records are drained one at a time through a shift register
//   and sent as a fixed-length byte packet over a valid/ready handshake to
//   the UART transmitter.
//
//   Packet layout (9 bytes, most significant first):
//     {cyctype_dir, data_size}, addr[31:24] .. addr[7:0], data[31:24] .. data[7:0]
//
// Optional feature (macro LPC_SER_SYNC_EN):
//   When defined, every packet is prefixed with SYNC_BYTE (10 bytes total).
//   When undefined, packets are 9 bytes and SYNC_BYTE is unused.
//
// Ports:
//   lpc_clock       in   1          clock, all logic on the rising edge
//   lpc_reset       in   1          asynchronous active-low reset
//   in_cyctype_dir  in   4          decoder cycle type / direction
//   in_addr         in   32         decoder address
//   in_data         in   32         decoder data
//   in_data_size    in   4          decoder data size
//   in_strobe       in   1          decoder output strobe (edge-detected)
//   tx_data         out  8          byte to UART
//   tx_valid        out  1          tx_data is valid
//   tx_ready        in   1          UART accepts the byte
//   fifo_level      out  FIFO_AW+1  records currently queued
//   overflow        out  1          sticky, a record was dropped
//   drop_count      out  8          dropped records, saturating at 8'hFF
// -----------------------------------------------------------------------------
module lpc_record_serializer #(
   parameter int         FIFO_AW   = 3,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic               lpc_clock,
   input  logic               lpc_reset,
   input  logic [3:0]         in_cyctype_dir,
   input  logic [31:0]        in_addr,
   input  logic [31:0]        in_data,
   input  logic [3:0]         in_data_size,
   input  logic               in_strobe,
   output logic [7:0]         tx_data,
   output logic               tx_valid,
   input  logic               tx_ready,
   output logic [FIFO_AW:0]   fifo_level,
   output logic               overflow,
   output logic [7:0]         drop_count
);

`ifdef LPC_SER_SYNC_EN
   localparam int NBYTES = 10;
`else
   localparam int NBYTES = 9;
   // Parameter is kept for interface compatibility with the sync build.
   logic [7:0] unused_sync_byte;
   assign unused_sync_byte = SYNC_BYTE;
`endif

   localparam int SR_W  = NBYTES * 8;
   localparam int DEPTH = 1 << FIFO_AW;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_SEND = 2'd2;

   logic [71:0]          mem [DEPTH];
   logic [FIFO_AW-1:0]   wr_ptr;
   logic [FIFO_AW-1:0]   rd_ptr;
   logic                 strobe_q;
   logic [1:0]           state;
   logic [SR_W-1:0]      shreg;
   logic [3:0]           byte_idx;
   logic [SR_W-1:0]      frame;

   logic push_req, push, pop, drop;
   logic fifo_empty, fifo_full, xfer, last_byte;

   assign push_req   = in_strobe & ~strobe_q;
   assign fifo_empty = (fifo_level == '0);
   assign fifo_full  = (fifo_level == (FIFO_AW+1)'(DEPTH));
   assign xfer       = tx_valid & tx_ready;
   assign last_byte  = (byte_idx == 4'(NBYTES - 1));

`ifdef LPC_SER_SYNC_EN
   assign frame = {SYNC_BYTE, mem[rd_ptr]};
`else
   assign frame = mem[rd_ptr];
`endif

   // A pop is only ever taken from a non-empty FIFO, so a push into an empty
   // FIFO cannot bypass straight to the shift register.
   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      pop = 1'b0;
      case (state)
         ST_IDLE: pop = ~fifo_empty;
         ST_SEND: pop = xfer & last_byte & ~fifo_empty;
         default: pop = 1'b0;
      endcase
   end

   // A full FIFO still accepts a record when a slot frees in the same cycle.
   assign push = push_req & (~fifo_full | pop);
   assign drop = push_req & fifo_full & ~pop;

   // NOTE: the record storage has no reset; only the pointers and level
   // define which entries are meaningful, so resetting the array buys nothing.
   always_ff @(posedge lpc_clock) begin
      if (push) mem[wr_ptr] <= {in_cyctype_dir, in_data_size, in_addr, in_data};
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge lpc_clock or negedge lpc_reset) begin
      if (!lpc_reset) begin
         strobe_q   <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         strobe_q <= in_strobe;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
         end
      end
   end

   // Packet FSM. tx_valid is raised in LOAD and dropped only after the last
   // byte transfers, which leaves exactly one idle cycle between packets.
   always_ff @(posedge lpc_clock or negedge lpc_reset) begin
      if (!lpc_reset) begin
         state    <= ST_IDLE;
         shreg    <= '0;
         tx_valid <= 1'b0;
         byte_idx <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  shreg <= frame;
                  state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               tx_valid <= 1'b1;
               byte_idx <= '0;
               state    <= ST_SEND;
            end
            ST_SEND: begin
               if (xfer) begin
                  if (last_byte) begin
                     tx_valid <= 1'b0;
                     if (pop) begin
                        shreg <= frame;
                        state <= ST_LOAD;
                     end else begin
                        state <= ST_IDLE;
                     end
                  end else begin
                     byte_idx <= byte_idx + 1'b1;
                     shreg    <= shreg << 8;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign tx_data = shreg[SR_W-1 -: 8];

endmodule
